// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: boot/load sequencer for the program memory.
// Holds the core in reset and streams instruction words into consecutive
// program-memory addresses. It then releases the core and forwards its fetch
// requests to the memory read port.
//
// Optional feature macro: PROG_LOAD_CHECKSUM_EN. When it is defined, the
// controller takes one trailing checksum word after the data and enters ERR
// if that word does not match.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, load_len     begin a load of load_len words (clamped to 2^ADDR_W)
//   s_valid/s_ready/s_data  loader word stream
//   mem_wr_addr/mem_wr_data/mem_we  program-memory write port (registered)
//   fetch_req, fetch_pc core fetch request
//   mem_rden, mem_rd_addr  program-memory read port (pass-through in RUN)
//   core_rst, busy, done, err  status
module prog_load_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [1:0]        mem_we,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_FLUSH,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   remain;
    logic [ADDR_W:0]   len_clamped;
    logic              handshake;
    logic              start_ok;

    assign len_clamped = (load_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : load_len;
    assign handshake   = s_valid & s_ready;
    assign start_ok    = start & ((state == S_IDLE) | (state == S_RUN) | (state == S_ERR));

`ifdef PROG_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic              err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Read port is live only while the core runs.
    assign mem_rden    = (state == S_RUN) & fetch_req;
    assign mem_rd_addr = (state == S_RUN) ? fetch_pc : '0;

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_RUN: begin
                if (start) state_nxt = (len_clamped == '0) ? S_FLUSH : S_LOAD;
            end
            S_LOAD: begin
                if (handshake && remain == (ADDR_W+1)'(1)) begin
`ifdef PROG_LOAD_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_FLUSH;
`endif
                end
            end
`ifdef PROG_LOAD_CHECKSUM_EN
            S_CHECK: begin
                if (handshake) state_nxt = (s_data == csum) ? S_FLUSH : S_ERR;
            end
            S_ERR: begin
                if (start) state_nxt = (len_clamped == '0) ? S_FLUSH : S_LOAD;
            end
`endif
            S_FLUSH: state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, registered status outputs and the write datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            core_rst    <= 1'b1;
            mem_we      <= 2'b00;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            wr_ptr      <= '0;
            remain      <= '0;
`ifdef PROG_LOAD_CHECKSUM_EN
            csum        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            s_ready  <= (state_nxt == S_LOAD) | (state_nxt == S_CHECK);
            busy     <= (state_nxt == S_LOAD) | (state_nxt == S_CHECK) | (state_nxt == S_FLUSH);
            done     <= (state_nxt == S_RUN);
            core_rst <= (state_nxt != S_RUN);
`ifdef PROG_LOAD_CHECKSUM_EN
            err_q    <= (state_nxt == S_ERR);
`endif
            mem_we   <= 2'b00;

            if (start_ok) begin
                remain <= len_clamped;
                wr_ptr <= '0;
`ifdef PROG_LOAD_CHECKSUM_EN
                csum   <= '0;
`endif
            end

            // A data word is written one cycle after its handshake.
            if (state == S_LOAD && handshake) begin
                mem_we      <= 2'b11;
                mem_wr_addr <= wr_ptr;
                mem_wr_data <= s_data;
                wr_ptr      <= wr_ptr + ADDR_W'(1);
                remain      <= remain - (ADDR_W+1)'(1);
`ifdef PROG_LOAD_CHECKSUM_EN
                csum        <= csum + s_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Testbench for prog_load_ctrl: a vector table for the basic load, fetch and
// restart flow, plus hand-written sequences for the multi-cycle corner cases.
module tb_prog_load_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst, start, s_valid, s_ready, fetch_req, mem_rden;
    logic              core_rst, busy, done, err;
    logic [ADDR_W:0]   load_len;
    logic [DATA_W-1:0] s_data, mem_wr_data;
    logic [ADDR_W-1:0] mem_wr_addr, fetch_pc, mem_rd_addr;
    logic [1:0]        mem_we;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prog_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .load_len(load_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_we(mem_we),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .mem_rden(mem_rden), .mem_rd_addr(mem_rd_addr),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic        rst, start;
        logic [8:0]  len;
        logic        sv;
        logic [15:0] sd;
        logic        fr;
        logic [7:0]  pc;
        logic        rdy, bsy, dn, crst, er;
        logic [1:0]  we;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic        rden;
        logic [7:0]  ra;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rst = 1'b0; start = 1'b0; load_len = '0; s_valid = 1'b0; s_data = '0;
        fetch_req = 1'b0; fetch_pc = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic add(input logic r, input logic st, input logic [8:0] len,
                       input logic sv, input logic [15:0] sd, input logic fr,
                       input logic [7:0] pc, input logic rdy, input logic bsy,
                       input logic dn, input logic crst, input logic er,
                       input logic [1:0] we, input logic [7:0] wa,
                       input logic [15:0] wd, input logic rden, input logic [7:0] ra);
        vec_t v;
        v.rst = r; v.start = st; v.len = len; v.sv = sv; v.sd = sd; v.fr = fr; v.pc = pc;
        v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.crst = crst; v.er = er;
        v.we = we; v.wa = wa; v.wd = wd; v.rden = rden; v.ra = ra;
        tbl.push_back(v);
    endtask

    // Full-depth load: len_in words requested, 256 actually transferred.
    task automatic full_load(input logic [8:0] len_in);
        logic [15:0] sum;
        sum = '0;
        do_reset();
        start = 1'b1; load_len = len_in;
        tick();
        start = 1'b0;
        chk("full_busy", busy, 1);
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1; s_data = 16'(i * 3 + 1);
            sum = sum + s_data;
            tick();
            chk("full_we", mem_we, 2'b11);
            chk("full_addr", mem_wr_addr, i);
        end
        s_valid = 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
        s_valid = 1'b1; s_data = sum;
        tick();
        s_valid = 1'b0;
        chk("full_ck_we", mem_we, 2'b00);
`endif
        chk("full_flush_rdy", s_ready, 0);
        chk("full_flush_crst", core_rst, 1);
        tick();
        chk("full_run_done", done, 1);
        chk("full_run_crst", core_rst, 0);
        fetch_req = 1'b1; fetch_pc = 8'hFF;
        #1;
        chk("fetch_rden", mem_rden, 1);
        chk("fetch_addr", mem_rd_addr, 8'hFF);
        fetch_req = 1'b0;
    endtask

    initial begin
        // Basic load of 4 words, fetch forwarding, restart from RUN, reset.
        add(1,0,0,   0,16'h0000,0,8'h00, 0,0,0,1,0, 2'b00,8'd0,16'h0000, 0,8'h00);
        add(0,1,4,   0,16'h0000,0,8'h00, 1,1,0,1,0, 2'b00,8'd0,16'h0000, 0,8'h00);
        add(0,0,0,   1,16'h1111,0,8'h00, 1,1,0,1,0, 2'b11,8'd0,16'h1111, 0,8'h00);
        add(0,0,0,   1,16'h2222,0,8'h00, 1,1,0,1,0, 2'b11,8'd1,16'h2222, 0,8'h00);
        add(0,0,0,   1,16'h3333,0,8'h00, 1,1,0,1,0, 2'b11,8'd2,16'h3333, 0,8'h00);
`ifdef PROG_LOAD_CHECKSUM_EN
        add(0,0,0,   1,16'h4444,0,8'h00, 1,1,0,1,0, 2'b11,8'd3,16'h4444, 0,8'h00);
        add(0,0,0,   1,16'hAAAA,0,8'h00, 0,1,0,1,0, 2'b00,8'd3,16'h4444, 0,8'h00);
`else
        add(0,0,0,   1,16'h4444,0,8'h00, 0,1,0,1,0, 2'b11,8'd3,16'h4444, 0,8'h00);
`endif
        add(0,0,0,   0,16'h0000,1,8'h12, 0,0,1,0,0, 2'b00,8'd3,16'h4444, 1,8'h12);
        add(0,0,0,   0,16'h0000,0,8'h34, 0,0,1,0,0, 2'b00,8'd3,16'h4444, 0,8'h34);
        add(0,1,2,   0,16'h0000,1,8'h55, 1,1,0,1,0, 2'b00,8'd3,16'h4444, 0,8'h00);
        add(0,0,0,   1,16'hABCD,0,8'h00, 1,1,0,1,0, 2'b11,8'd0,16'hABCD, 0,8'h00);
`ifdef PROG_LOAD_CHECKSUM_EN
        add(0,1,7,   1,16'h0BCD,0,8'h00, 1,1,0,1,0, 2'b11,8'd1,16'h0BCD, 0,8'h00);
        add(0,0,0,   1,16'hB79A,0,8'h00, 0,1,0,1,0, 2'b00,8'd1,16'h0BCD, 0,8'h00);
`else
        add(0,1,7,   1,16'h0BCD,0,8'h00, 0,1,0,1,0, 2'b11,8'd1,16'h0BCD, 0,8'h00);
`endif
        add(0,0,0,   0,16'h0000,0,8'h00, 0,0,1,0,0, 2'b00,8'd1,16'h0BCD, 0,8'h00);
        add(1,0,0,   0,16'h0000,0,8'h00, 0,0,0,1,0, 2'b00,8'd0,16'h0000, 0,8'h00);

        idle_in();
        foreach (tbl[i]) begin
            rst = tbl[i].rst; start = tbl[i].start; load_len = tbl[i].len;
            s_valid = tbl[i].sv; s_data = tbl[i].sd;
            fetch_req = tbl[i].fr; fetch_pc = tbl[i].pc;
            tick();
            chk($sformatf("v%0d_s_ready", i),  s_ready,     tbl[i].rdy);
            chk($sformatf("v%0d_busy", i),     busy,        tbl[i].bsy);
            chk($sformatf("v%0d_done", i),     done,        tbl[i].dn);
            chk($sformatf("v%0d_core_rst", i), core_rst,    tbl[i].crst);
            chk($sformatf("v%0d_err", i),      err,         tbl[i].er);
            chk($sformatf("v%0d_mem_we", i),   mem_we,      tbl[i].we);
            chk($sformatf("v%0d_wr_addr", i),  mem_wr_addr, tbl[i].wa);
            chk($sformatf("v%0d_wr_data", i),  mem_wr_data, tbl[i].wd);
            chk($sformatf("v%0d_rden", i),     mem_rden,    tbl[i].rden);
            chk($sformatf("v%0d_rd_addr", i),  mem_rd_addr, tbl[i].ra);
        end

        // Backpressure: s_valid low on alternate cycles.
        do_reset();
        start = 1'b1; load_len = 9'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = (i % 2 == 0);
            s_data  = 16'hA000 + 16'(i);
            tick();
            if (i % 2 == 0) begin
                chk("bp_we", mem_we, 2'b11);
                chk("bp_addr", mem_wr_addr, i / 2);
                chk("bp_data", mem_wr_data, 16'hA000 + 16'(i));
            end else begin
                chk("bp_gap_we", mem_we, 2'b00);
            end
        end
        s_valid = 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
        s_valid = 1'b1; s_data = 16'hA000 + 16'hA002 + 16'hA004;
        tick();
        s_valid = 1'b0;
`endif
        chk("bp_flush_crst", core_rst, 1);
        tick();
        chk("bp_run_done", done, 1);

        // Zero length: straight through FLUSH to RUN.
        do_reset();
        start = 1'b1; load_len = 9'd0;
        tick();
        start = 1'b0;
        chk("zero_rdy0", s_ready, 0);
        chk("zero_busy0", busy, 1);
        chk("zero_done0", done, 0);
        chk("zero_crst0", core_rst, 1);
        tick();
        chk("zero_rdy1", s_ready, 0);
        chk("zero_done1", done, 1);
        chk("zero_crst1", core_rst, 0);

        // Full depth, and an over-range length that must clamp.
        full_load(9'd256);
        full_load(9'd300);

        // Reset in the middle of a load.
        do_reset();
        start = 1'b1; load_len = 9'd4;
        tick();
        start = 1'b0; s_valid = 1'b1; s_data = 16'h0101;
        tick();
        s_data = 16'h0202;
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_rdy", s_ready, 0);
        chk("mrst_we", mem_we, 2'b00);
        chk("mrst_wa", mem_wr_addr, 0);
        chk("mrst_wd", mem_wr_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_crst", core_rst, 1);
        chk("mrst_err", err, 0);
        rst = 1'b0;
        tick();
        chk("mrst_idle_rdy", s_ready, 0);
        chk("mrst_idle_we", mem_we, 2'b00);
        s_valid = 1'b0;

`ifdef PROG_LOAD_CHECKSUM_EN
        // Checksum mismatch then a good retry from ERR.
        do_reset();
        start = 1'b1; load_len = 9'd2;
        tick();
        start = 1'b0; s_valid = 1'b1; s_data = 16'h0001;
        tick();
        s_data = 16'h0002;
        tick();
        s_data = 16'h0004;
        tick();
        s_valid = 1'b0;
        chk("ck_bad_we", mem_we, 2'b00);
        chk("ck_bad_err", err, 1);
        chk("ck_bad_crst", core_rst, 1);
        chk("ck_bad_rdy", s_ready, 0);
        tick();
        chk("ck_bad_err_hold", err, 1);
        chk("ck_bad_done", done, 0);
        start = 1'b1; load_len = 9'd2;
        tick();
        start = 1'b0; s_valid = 1'b1; s_data = 16'h0001;
        chk("ck_retry_err", err, 0);
        tick();
        s_data = 16'h0002;
        tick();
        s_data = 16'h0003;
        tick();
        s_valid = 1'b0;
        chk("ck_good_err", err, 0);
        tick();
        chk("ck_good_done", done, 1);
        chk("ck_good_crst", core_rst, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_load_ctrl.md
# prog_load_ctrl

Boot and load sequencer for the 256 x 16 program memory. Holds the core in reset and accepts a stream of instruction words over a valid/ready handshake. Writes each word into consecutive program-memory addresses, then releases the core and forwards its fetch requests to the memory read port. Sits between the external loader interface, the core's fetch stage and the program memory.

## Interface
- `ADDR_W`, 8, program-memory address width (depth = 2^ADDR_W)
- `DATA_W`, 16, instruction word width
- `clk` in 1, system clock; all state changes on the rising edge
- `rst` in 1, synchronous, active-high reset
- `start` in 1, single-cycle pulse that begins a load
- `load_len` in ADDR_W+1, word count sampled on `start`
  - valid range 0..2^ADDR_W; larger values clamp to 2^ADDR_W
- `s_valid` in 1, loader word valid
- `s_ready` out 1, controller accepts a word this cycle
- `s_data` in DATA_W, loader word
- `mem_wr_addr` out ADDR_W, program-memory write address
- `mem_wr_data` out DATA_W, program-memory write data
- `mem_we` out 2, program-memory write enable; 2'b11 = write, 2'b00 otherwise
- `fetch_req` in 1, core fetch request
- `fetch_pc` in ADDR_W, core fetch address
- `mem_rden` out 1, program-memory read enable
- `mem_rd_addr` out ADDR_W, program-memory read address
- `core_rst` out 1, core reset, active-high
- `busy` out 1, high while loading, checking or flushing
- `done` out 1, high while in RUN
- `err` out 1, checksum failure flag; tied 0 when the checksum feature is compiled out

## Operation
- States: IDLE, LOAD, CHECK (macro only), FLUSH, RUN, ERR.
- IDLE:
  - `core_rst`=1, `s_ready`=0.
  - `start` latches the clamped `load_len` into `remain`, clears `wr_ptr` and the checksum, then goes to LOAD.
  - If `load_len`=0, goes to FLUSH instead.
- LOAD:
  - `s_ready`=1.
  - Each handshake (`s_valid & s_ready`) registers `mem_wr_addr`=`wr_ptr`, `mem_wr_data`=`s_data`, `mem_we`=2'b11 for the next cycle.
  - Each handshake increments `wr_ptr` (wraps modulo 2^ADDR_W), decrements `remain` and adds the word to the checksum.
  - When the handshake consumes the final word (`remain`=1), goes to CHECK if the macro is defined, otherwise to FLUSH.
- CHECK: see Configuration.
- FLUSH:
  - One cycle; the final registered write completes here.
  - `s_ready`=0, `core_rst`=1. Goes to RUN.
- RUN:
  - `core_rst`=0, `done`=1.
  - `mem_rden`=`fetch_req`, `mem_rd_addr`=`fetch_pc` (combinational pass-through).
  - Outside RUN, `mem_rden`=0 and `mem_rd_addr`=0.
- ERR: `core_rst`=1, `err`=1, `s_ready`=0. Only `start` or `rst` leaves this state.
- `start` in RUN or ERR restarts the load:
  - next state is LOAD (or FLUSH when `load_len`=0);
  - `core_rst` reasserts from the next cycle.
- `start` in LOAD, CHECK or FLUSH is ignored.
- `mem_we` is 2'b00 in every cycle without a pending write. Read and write never overlap, because reads occur only in RUN.

## Timing
- Reset values:
  - state IDLE, `core_rst`=1;
  - `s_ready`, `mem_we`, `mem_wr_addr`, `mem_wr_data`, `mem_rden`, `mem_rd_addr`, `busy`, `done`, `err` all 0;
  - `wr_ptr`=0, `remain`=0, checksum 0.
- `s_ready`, `busy`, `done`, `core_rst` and `err` are registered functions of state.
- Write latency: a handshake at edge k drives `mem_we`=2'b11 during cycle k..k+1, and memory captures the word at edge k+1.
- Release: the final handshake is at edge k (no macro).
  - FLUSH occupies cycles k..k+1.
  - `core_rst` falls and `done` rises after edge k+1.
  - The first legal fetch is presented in the cycle after edge k+1; `instr` returns one cycle after that, which is the memory's latency.
- `len`=0: IDLE → FLUSH → RUN. `core_rst` falls 2 cycles after `start`.
- `rst` mid-load aborts immediately. Words already written stay in memory.
- `len`=256: addresses 0..255 are written, and `wr_ptr` ends at 0.

## Configuration
- `PROG_LOAD_CHECKSUM_EN` defined:
  - After the final data word, the state goes to CHECK with `s_ready`=1.
  - CHECK accepts exactly one extra word, which is compared against the 16-bit modulo-2^16 sum of all data words.
  - This word is not written to memory.
  - On a match, goes to FLUSH; on a mismatch, goes to ERR.
- `PROG_LOAD_CHECKSUM_EN` undefined: no CHECK or ERR state, `err` tied 0, and no extra word is consumed.

## Test plan
- **Basic load.** Reset, `start` with `load_len`=4, words 0x1111/0x2222/0x3333/0x4444 with `s_valid` held high.
  - `mem_we`=2'b11 on 4 consecutive cycles at addresses 0..3.
  - `core_rst` falls 2 cycles after the last handshake.
- **Backpressure gaps.** `load_len`=3 with `s_valid` low on alternate cycles.
  - Addresses 0,1,2 are written only on handshake cycles.
  - `mem_we`=00 in the gap cycles.
- **Zero length.** `start` with `load_len`=0.
  - `s_ready` never rises.
  - `done`=1 two cycles after `start`.
- **Fetch forwarding and wrap.** Full load with `load_len`=256 (and 300, which clamps).
  - Last write is at address 255.
  - In RUN, `fetch_req`=1 with `fetch_pc`=0xFF gives `mem_rden`=1 and `mem_rd_addr`=0xFF in the same cycle.
- **Restart and reset.** `start` during RUN.
  - `core_rst`=1 the next cycle and the load restarts at address 0.
  - Separately, `rst` after 2 of 4 words: all outputs return to reset values on the next edge.
- **Checksum mismatch (macro on).** Words 0x0001, 0x0002, then checksum word 0x0004.
  - `err`=1 and `core_rst` stays 1.
  - With checksum word 0x0003: RUN is reached and `err`=0.
